note_tone_generator: RTL and testbench
======================================

NOTE_TONE_GENERATOR -- requirements
Module: note_tone_generator

Interface
REQ-001 Parameter DIV_W, default 11: width of the half-period counter; every table entry SHALL fit in DIV_W bits.
REQ-002 iClk  input  1  clock, 1 MHz, rising edge.
REQ-003 iReset_n  input  1  reset, synchronous, active-low.
REQ-004 iRing  input  1  play enable from the buzzer-duration counter; 1 = note may sound.
REQ-005 iNote  input  5  note code: 0 = rest; 1..21 = C4..B6 (7 notes × 3 octaves); 22..31 invalid.
REQ-006 iVolume  input  2  duty select; exists only when TONE_VOLUME_EN is defined.
REQ-007 oBuzzer  output  1  square wave to the piezo buzzer.
REQ-008 oBusy  output  1  1 while the state is PLAY or RELEASE.
REQ-009 oNote  output  5  note currently sounding; 0 when idle.

Function
REQ-010 States SHALL be IDLE, PLAY and RELEASE.
REQ-011 Half-period table (cycles): C4..B4 = 1911,1703,1517,1432,1276,1136,1012; C5..B5 = 956,851,758,716,638,568,506; C6..B6 = 478,426,379,358,319,284,253.
REQ-012 IDLE, iRing=1 and iNote in 1..21 at edge N: latch note and half-period, go to PLAY, and drive oBuzzer=1, oNote=iNote, oBusy=1, all registered at edge N.
REQ-013 IDLE with iNote=0 or iNote>21: stay IDLE, latch nothing, keep outputs 0.
REQ-014 PLAY/RELEASE: a counter SHALL run 0..H-1 in the high phase and 0..L-1 in the low phase, then toggle oBuzzer; without TONE_VOLUME_EN, H=L=half-period.
REQ-015 A period boundary is the low-to-high transition; a new note, a new iVolume and a rest SHALL take effect only at a period boundary, never mid-period.
REQ-016 PLAY with iRing=1 and a changed valid iNote: update oNote and the half-period at the next period boundary; the new note's high phase starts there.
REQ-017 PLAY with iRing=1 and iNote=0 or invalid: finish the current period, then go to IDLE.
REQ-018 PLAY with iRing=0: go to RELEASE on the next edge; the waveform continues unchanged.
REQ-019 RELEASE with iRing=0: at the end of the low phase go to IDLE, with oBuzzer=0, oBusy=0 and oNote=0.
REQ-020 RELEASE with iRing=1: return to PLAY without a phase or counter restart.
REQ-021 If iRing falls and the period ends on the same edge: go directly to IDLE.
REQ-022 The counter SHALL never wrap; the terminal count SHALL always reload it to 0.

Reset
REQ-023 iReset_n=0 at any edge: state=IDLE, counter=0, oBuzzer=0, oBusy=0, oNote=0, latched period=0; this SHALL abort mid-note with no trailing edge.
REQ-024 The first note after reset release SHALL obey REQ-012.

Configuration
REQ-025 Macro TONE_VOLUME_EN defined: the iVolume port SHALL exist.
REQ-026 With TONE_VOLUME_EN: H=(half>>2)*(iVolume+1) and L=2*half-H, with iVolume sampled at the period boundary; iVolume=3 gives 50% duty.
REQ-027 Without TONE_VOLUME_EN: there SHALL be no iVolume port and the duty SHALL be fixed at 50%.

Structure
REQ-028 A shared package SHALL hold the state enum, NOTE_REST=0, NOTE_MAX=21, and the 21 half-period constants.
REQ-029 A sub-module note_period_rom SHALL provide the combinational mapping from note code to half-period, returning 0 for invalid codes.

Verification
REQ-030 The bench SHALL cover:
- iNote=6 with iRing=1 held -> oBuzzer alternates 1136 cycles high / 1136 cycles low; oNote=6; oBusy=1.
- Change iNote from 6 to 13 mid-high-phase -> the 6 waveform completes its full period, then high phases last 568 cycles; oNote changes only at that boundary.
- iRing falls 100 cycles into the high phase of note 21 -> 153 more high cycles, 253 low cycles, then oBusy=0 and oBuzzer=0.
- iNote=25 or iNote=0 with iRing=1 from IDLE -> outputs stay 0 for 5000 cycles.
- Reset asserted mid-period of note 1 -> all outputs 0 on the next edge; iNote=1 re-applied -> fresh 1911-cycle high phase.
- TONE_VOLUME_EN defined, iNote=6, iVolume=0 -> 284 cycles high / 1988 cycles low.

Source files
------------

// File: rtl/note_tone_generator_pkg.sv
// Shared types and constants for the note tone generator: FSM states,
// note-code limits and the half-period table (1 MHz clock cycles).
package note_tone_generator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } toneState_t;

  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_MAX  = 5'd21;

  localparam int HALF_C4 = 1911, HALF_D4 = 1703, HALF_E4 = 1517, HALF_F4 = 1432;
  localparam int HALF_G4 = 1276, HALF_A4 = 1136, HALF_B4 = 1012;
  localparam int HALF_C5 = 956,  HALF_D5 = 851,  HALF_E5 = 758,  HALF_F5 = 716;
  localparam int HALF_G5 = 638,  HALF_A5 = 568,  HALF_B5 = 506;
  localparam int HALF_C6 = 478,  HALF_D6 = 426,  HALF_E6 = 379,  HALF_F6 = 358;
  localparam int HALF_G6 = 319,  HALF_A6 = 284,  HALF_B6 = 253;

  function automatic logic noteValid(input logic [4:0] note);
    return (note != NOTE_REST) && (note <= NOTE_MAX);
  endfunction

endpackage

// File: rtl/note_period_rom.sv
// Combinational note-code to half-period lookup; rests and invalid codes give 0.
module note_period_rom
  import note_tone_generator_pkg::*;
#(
  parameter int DIV_W = 11
) (
  input  logic [4:0]       note,
  output logic [DIV_W-1:0] halfPeriod
);

  always_comb begin
    halfPeriod = '0;
    case (note)
      5'd1:  halfPeriod = DIV_W'(HALF_C4);
      5'd2:  halfPeriod = DIV_W'(HALF_D4);
      5'd3:  halfPeriod = DIV_W'(HALF_E4);
      5'd4:  halfPeriod = DIV_W'(HALF_F4);
      5'd5:  halfPeriod = DIV_W'(HALF_G4);
      5'd6:  halfPeriod = DIV_W'(HALF_A4);
      5'd7:  halfPeriod = DIV_W'(HALF_B4);
      5'd8:  halfPeriod = DIV_W'(HALF_C5);
      5'd9:  halfPeriod = DIV_W'(HALF_D5);
      5'd10: halfPeriod = DIV_W'(HALF_E5);
      5'd11: halfPeriod = DIV_W'(HALF_F5);
      5'd12: halfPeriod = DIV_W'(HALF_G5);
      5'd13: halfPeriod = DIV_W'(HALF_A5);
      5'd14: halfPeriod = DIV_W'(HALF_B5);
      5'd15: halfPeriod = DIV_W'(HALF_C6);
      5'd16: halfPeriod = DIV_W'(HALF_D6);
      5'd17: halfPeriod = DIV_W'(HALF_E6);
      5'd18: halfPeriod = DIV_W'(HALF_F6);
      5'd19: halfPeriod = DIV_W'(HALF_G6);
      5'd20: halfPeriod = DIV_W'(HALF_A6);
      5'd21: halfPeriod = DIV_W'(HALF_B6);
      default: halfPeriod = '0;
    endcase
  end

endmodule

// File: rtl/note_tone_generator.sv
// Square-wave piezo driver: plays the requested note, switching notes only at
// period boundaries. Define TONE_VOLUME_EN to add the iVolume duty-select port.
module note_tone_generator
  import note_tone_generator_pkg::*;
#(
  parameter int DIV_W = 11
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iRing,
  input  logic [4:0] iNote,
`ifdef TONE_VOLUME_EN
  input  logic [1:0] iVolume,
`endif
  output logic       oBuzzer,
  output logic       oBusy,
  output logic [4:0] oNote
);

  // The low phase can reach 2*half when the duty is reduced, so it needs a spare bit.
`ifdef TONE_VOLUME_EN
  localparam int CNT_W = DIV_W + 1;
`else
  localparam int CNT_W = DIV_W;
`endif

  toneState_t       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext, hiLen, loLen, phaseLen;
  logic [DIV_W-1:0] halfQ, halfNext, halfIn;
  logic             buzzNext;
  logic [4:0]       noteNext;
  logic             load, phaseEnd, boundary;

  note_period_rom #(.DIV_W(DIV_W)) uRom (.note(iNote), .halfPeriod(halfIn));

`ifdef TONE_VOLUME_EN
  logic [1:0]       volQ, volNext;
  logic [CNT_W-1:0] quarter;
  assign quarter = CNT_W'(halfQ >> 2);
  assign hiLen   = quarter * (CNT_W'(volQ) + CNT_W'(1));
  assign loLen   = {halfQ, 1'b0} - hiLen;
`else
  assign hiLen = CNT_W'(halfQ);
  assign loLen = CNT_W'(halfQ);
`endif

  assign phaseLen = oBuzzer ? hiLen : loLen;
  assign phaseEnd = (cnt == phaseLen - CNT_W'(1));
  assign boundary = (state != IDLE) && phaseEnd && !oBuzzer;
  assign load     = iRing && noteValid(iNote);
  assign oBusy    = (state != IDLE);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    buzzNext  = oBuzzer;
    noteNext  = oNote;
    halfNext  = halfQ;
`ifdef TONE_VOLUME_EN
    volNext   = volQ;
`endif
    if (state == IDLE || boundary) begin
      // Note start, note change, rest and release all resolve here only.
      if (load) begin
        stateNext = PLAY;
        cntNext   = '0;
        buzzNext  = 1'b1;
        noteNext  = iNote;
        halfNext  = halfIn;
`ifdef TONE_VOLUME_EN
        volNext   = iVolume;
`endif
      end else begin
        stateNext = IDLE;
        cntNext   = '0;
        buzzNext  = 1'b0;
        noteNext  = NOTE_REST;
        halfNext  = '0;
      end
    end else begin
      stateNext = iRing ? PLAY : RELEASE;
      if (phaseEnd) begin
        cntNext  = '0;
        buzzNext = 1'b0;
      end else begin
        cntNext  = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      oBuzzer <= 1'b0;
      oNote   <= NOTE_REST;
      halfQ   <= '0;
`ifdef TONE_VOLUME_EN
      volQ    <= '0;
`endif
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      oBuzzer <= buzzNext;
      oNote   <= noteNext;
      halfQ   <= halfNext;
`ifdef TONE_VOLUME_EN
      volQ    <= volNext;
`endif
    end
  end

endmodule

// File: tb/tb_note_tone_generator.sv
// Self-checking bench for note_tone_generator: vector table, corner sequences
// and a randomized run against a period-timer reference model.
`timescale 1ns/1ps
module tb_note_tone_generator;

  logic       iClk = 1'b0;
  logic       iReset_n = 1'b0;
  logic       iRing = 1'b0;
  logic [4:0] iNote = 5'd0;
  logic [1:0] iVolume = 2'd3;
  logic       oBuzzer, oBusy;
  logic [4:0] oNote;

`ifdef TONE_VOLUME_EN
  localparam bit VOL_EN = 1'b1;
  localparam int HI1 = 1908, HI21 = 252, LO21 = 254;
`else
  localparam bit VOL_EN = 1'b0;
  localparam int HI1 = 1911, HI21 = 253, LO21 = 253;
`endif

  note_tone_generator #(.DIV_W(11)) dut (
    .iClk(iClk),
    .iReset_n(iReset_n),
    .iRing(iRing),
    .iNote(iNote),
`ifdef TONE_VOLUME_EN
    .iVolume(iVolume),
`endif
    .oBuzzer(oBuzzer),
    .oBusy(oBusy),
    .oNote(oNote)
  );

  always #500 iClk = ~iClk;

  int passCnt = 0, totalCnt = 0, randFails = 0;
  int spec[21] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012,
                   956, 851, 758, 716, 638, 568, 506,
                   478, 426, 379, 358, 319, 284, 253};

  // Reference: one timer counts through the whole period (2*half cycles);
  // the buzzer is high for the first hi cycles of it.
  int mActive = 0, mNote = 0, mHalf = 0, mHi = 0, mT = 0;

  function automatic int halfOf(input int n);
    return (n >= 1 && n <= 21) ? spec[n-1] : 0;
  endfunction

  function automatic void modelLoad(input int n, input int v);
    mActive = 1;
    mNote   = n;
    mHalf   = halfOf(n);
    mHi     = VOL_EN ? (mHalf / 4) * (v + 1) : mHalf;
    mT      = 0;
  endfunction

  function automatic void modelStep(input logic rstn, input logic ring, input int n, input int v);
    bit ok = (n >= 1 && n <= 21);
    if (!rstn) begin
      mActive = 0; mNote = 0; mHalf = 0; mHi = 0; mT = 0;
    end else if (mActive == 0) begin
      if (ring && ok) modelLoad(n, v);
    end else if (mT == 2 * mHalf - 1) begin
      if (ring && ok) modelLoad(n, v);
      else begin mActive = 0; mNote = 0; mT = 0; end
    end else begin
      mT++;
    end
  endfunction

  task automatic tick();
    logic r, g;
    int   n, v;
    r = iReset_n; g = iRing; n = int'(iNote); v = int'(iVolume);
    @(posedge iClk);
    #1;
    modelStep(r, g, n, v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic applyReset();
    iReset_n = 1'b0; iRing = 1'b0; iNote = 5'd0;
    tick(); tick();
    iReset_n = 1'b1;
    tick();
  endtask

  // Counts consecutive samples with oBuzzer==val while busy; bounded by maxc.
  task automatic runLen(input logic val, input logic [4:0] expNote, input int maxc,
                        output int n, output int noteBad);
    n = 0; noteBad = 0;
    while (oBuzzer === val && oBusy === 1'b1 && n < maxc) begin
      if (oNote !== expNote) noteBad++;
      n++;
      tick();
    end
  endtask

  typedef struct {
    logic [4:0] note;
    int         hi;
    int         lo;
    int         watch;   // >0: invalid/rest code, outputs must stay 0 this long
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n, bad, expB, expN;

    vecs[0]  = '{5'd6,  1136, 1136, 0};
    vecs[1]  = '{5'd8,  956,  956,  0};
    vecs[2]  = '{5'd13, 568,  568,  0};
    vecs[3]  = '{5'd7,  1012, 1012, 0};
    vecs[4]  = '{5'd11, 716,  716,  0};
    vecs[5]  = '{5'd20, 284,  284,  0};
    vecs[6]  = '{5'd4,  1432, 1432, 0};
    vecs[7]  = '{5'd0,  0, 0, 5000};
    vecs[8]  = '{5'd25, 0, 0, 5000};
    vecs[9]  = '{5'd22, 0, 0, 300};
    vecs[10] = '{5'd31, 0, 0, 300};

    applyReset();
    check("reset_buzzer", int'(oBuzzer), 0);
    check("reset_busy", int'(oBusy), 0);
    check("reset_note", int'(oNote), 0);

    for (int i = 0; i < 11; i++) begin
      applyReset();
      iRing = 1'b1; iNote = vecs[i].note; iVolume = 2'd3;
      if (vecs[i].watch == 0) begin
        tick();
        check($sformatf("start_buzzer_n%0d", vecs[i].note), int'(oBuzzer), 1);
        check($sformatf("start_busy_n%0d", vecs[i].note), int'(oBusy), 1);
        check($sformatf("start_note_n%0d", vecs[i].note), int'(oNote), int'(vecs[i].note));
        runLen(1'b1, vecs[i].note, 5000, n, bad);
        check($sformatf("high_len_n%0d", vecs[i].note), n, vecs[i].hi);
        runLen(1'b0, vecs[i].note, 5000, n, bad);
        check($sformatf("low_len_n%0d", vecs[i].note), n, vecs[i].lo);
        check($sformatf("note_steady_n%0d", vecs[i].note), bad, 0);
        check($sformatf("next_period_n%0d", vecs[i].note), int'(oBuzzer), 1);
      end else begin
        bad = 0;
        for (int c = 0; c < vecs[i].watch; c++) begin
          tick();
          if (oBuzzer !== 1'b0 || oBusy !== 1'b0 || oNote !== 5'd0) bad++;
        end
        check($sformatf("idle_hold_n%0d", vecs[i].note), bad, 0);
      end
    end

    // Note change 6 -> 13 mid-high-phase: current period completes first.
    applyReset();
    iRing = 1'b1; iNote = 5'd6; iVolume = 2'd3;
    tick();
    for (int c = 0; c < 499; c++) tick();
    iNote = 5'd13;
    runLen(1'b1, 5'd6, 5000, n, bad);
    check("chg_rest_high6", n, 1136 - 499);
    check("chg_note_high6", bad, 0);
    runLen(1'b0, 5'd6, 5000, n, bad);
    check("chg_low6", n, 1136);
    check("chg_note_low6", bad, 0);
    check("chg_boundary_note", int'(oNote), 13);
    runLen(1'b1, 5'd13, 5000, n, bad);
    check("chg_high13", n, 568);
    runLen(1'b0, 5'd13, 5000, n, bad);
    check("chg_low13", n, 568);

    // Ring falls 100 cycles into the high phase of note 21.
    applyReset();
    iRing = 1'b1; iNote = 5'd21;
    tick();
    for (int c = 0; c < 100; c++) tick();
    iRing = 1'b0;
    runLen(1'b1, 5'd21, 5000, n, bad);
    check("rel_high_rest", n, HI21 - 100);
    runLen(1'b0, 5'd21, 5000, n, bad);
    check("rel_low", n, LO21);
    check("rel_busy", int'(oBusy), 0);
    check("rel_buzzer", int'(oBuzzer), 0);
    check("rel_note", int'(oNote), 0);

    // Reset mid-period of note 1, then a fresh note.
    applyReset();
    iRing = 1'b1; iNote = 5'd1;
    tick();
    for (int c = 0; c < 700; c++) tick();
    iReset_n = 1'b0;
    tick();
    check("rst_mid_buzzer", int'(oBuzzer), 0);
    check("rst_mid_busy", int'(oBusy), 0);
    check("rst_mid_note", int'(oNote), 0);
    iReset_n = 1'b1; iNote = 5'd0;
    tick();
    check("rst_after_buzzer", int'(oBuzzer), 0);
    check("rst_after_busy", int'(oBusy), 0);
    iNote = 5'd1;
    tick();
    check("rst_restart_buzzer", int'(oBuzzer), 1);
    runLen(1'b1, 5'd1, 5000, n, bad);
    check("rst_restart_high", n, HI1);

`ifdef TONE_VOLUME_EN
    applyReset();
    iRing = 1'b1; iNote = 5'd6; iVolume = 2'd0;
    tick();
    runLen(1'b1, 5'd6, 5000, n, bad);
    check("vol0_high", n, 284);
    runLen(1'b0, 5'd6, 5000, n, bad);
    check("vol0_low", n, 1988);
`endif

    // Randomized segments against the reference model, compared every cycle.
    applyReset();
    for (int seg = 0; seg < 40; seg++) begin
      int len;
      len = int'($urandom_range(1500, 20));
      iRing = ($urandom_range(9, 0) < 7);
      case ($urandom_range(9, 0))
        0: iNote = 5'd0;
        1: iNote = 5'($urandom_range(31, 22));
        2: iNote = 5'($urandom_range(14, 1));
        default: iNote = 5'($urandom_range(21, 15));
      endcase
      iVolume  = 2'($urandom_range(3, 0));
      iReset_n = ($urandom_range(29, 0) != 0);
      for (int c = 0; c < len; c++) begin
        tick();
        iReset_n = 1'b1;
        expB = (mActive != 0 && mT < mHi) ? 1 : 0;
        expN = (mActive != 0) ? mNote : 0;
        totalCnt++;
        if (int'(oBuzzer) == expB && int'(oBusy) == mActive && int'(oNote) == expN) begin
          passCnt++;
        end else begin
          if (randFails < 10)
            $display("FAIL random seg%0d cyc%0d: got buz=%0d busy=%0d note=%0d, expected buz=%0d busy=%0d note=%0d",
                     seg, c, oBuzzer, oBusy, oNote, expB, mActive, expN);
          randFails++;
        end
      end
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
